// File: rtl/ro_frame_deser.sv
// Readout-bus frame deserialiser: samples the shared bus once per clk_ext cycle, aligns slot
// numbering to clk_16 and queues one NSLOTS-slot frame word per clk_16 period behind valid/ready.
module ro_frame_deser #(
   parameter int NSLOTS     = 16,
   parameter int BUS_W      = 2,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                    clk_ext,
   input  logic                    rstb,
   input  logic                    clk_16,
   input  logic [BUS_W-1:0]        bus_in,
   input  logic                    clr_flags,
   output logic [NSLOTS*BUS_W-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    locked,
   output logic                    sync_err,
   output logic                    overflow,
   output logic [7:0]              frame_cnt
);

   localparam int FRAME_W = NSLOTS * BUS_W;
   localparam int SLOT_W  = $clog2(NSLOTS);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);

   localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOTS - 1);
   localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W + 1)'(1);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } state_t;

   // clk_16 synchroniser and rising-edge detect
   logic [2:0] sync_q;
   logic       sync_rise;

   always_ff @(posedge clk_ext or negedge rstb) begin
      if (!rstb) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], clk_16};
      end
   end

   assign sync_rise = sync_q[1] & ~sync_q[2];

   // Slot alignment FSM and frame assembly
   state_t             state_q, state_d;
   logic [SLOT_W-1:0]  slot_q, slot_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               push_q, push_d;
   logic               sync_set;

   always_ff @(posedge clk_ext or negedge rstb) begin
      if (!rstb) begin
         state_q <= UNLOCKED;
         slot_q  <= '0;
         push_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         push_q  <= push_d;
      end
   end

   // Frame contents are only meaningful once push_q qualifies them, so no reset is needed.
   always_ff @(posedge clk_ext) begin
      frame_q <= frame_d;
   end

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      frame_d  = frame_q;
      push_d   = 1'b0;
      sync_set = 1'b0;
      unique case (state_q)
         UNLOCKED: begin
            slot_d = '0;
            if (sync_rise) begin
               state_d = LOCKED;
               frame_d = FRAME_W'(bus_in);
               slot_d  = SLOT_ONE;
            end
         end
         LOCKED: begin
            if (sync_rise) begin
               // An edge anywhere but slot 0 restarts the frame; the partial one is dropped.
               sync_set = (slot_q != '0);
               frame_d  = FRAME_W'(bus_in);
               slot_d   = SLOT_ONE;
            end else if (slot_q == '0) begin
               sync_set = 1'b1;
               state_d  = UNLOCKED;
            end else begin
               frame_d[int'(slot_q)*BUS_W +: BUS_W] = bus_in;
               slot_d = slot_q + SLOT_ONE;
               push_d = (slot_q == LAST_SLOT);
            end
         end
         default: begin
            state_d = UNLOCKED;
            slot_d  = '0;
         end
      endcase
   end

   assign locked = (state_q == LOCKED);

   // Output FIFO: pointers carry one wrap bit to tell full from empty
   logic [PTR_W:0]     wptr_q, wptr_d;
   logic [PTR_W:0]     rptr_q, rptr_d;
   logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];
   logic               fifo_empty, fifo_full;
   logic               pop, push_ok, drop;
   logic [7:0]         frame_cnt_q, frame_cnt_d;

   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                       (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
   assign pop        = ~fifo_empty & out_ready;
   assign push_ok    = push_q & (~fifo_full | pop);
   assign drop       = push_q & fifo_full & ~pop;

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      frame_cnt_d = frame_cnt_q;
      if (pop) begin
         rptr_d = rptr_q + PTR_ONE;
      end
      if (push_ok) begin
         wptr_d      = wptr_q + PTR_ONE;
         frame_cnt_d = frame_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_ext or negedge rstb) begin
      if (!rstb) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         frame_cnt_q <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   always_ff @(posedge clk_ext) begin
      if (push_ok) begin
         mem_q[wptr_q[PTR_W-1:0]] <= frame_q;
      end
   end

   assign out_valid = ~fifo_empty;
   assign out_data  = fifo_empty ? '0 : mem_q[rptr_q[PTR_W-1:0]];
   assign frame_cnt = frame_cnt_q;

   // Sticky status; a set in the same cycle as clr_flags wins
   logic sync_err_q, sync_err_d;
   logic overflow_q, overflow_d;

   always_comb begin
      sync_err_d = sync_set | (sync_err_q & ~clr_flags);
      overflow_d = drop | (overflow_q & ~clr_flags);
   end

   always_ff @(posedge clk_ext or negedge rstb) begin
      if (!rstb) begin
         sync_err_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         sync_err_q <= sync_err_d;
         overflow_q <= overflow_d;
      end
   end

   assign sync_err = sync_err_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_ro_frame_deser.sv
// Directed bench for ro_frame_deser: table of aligned frames plus hand-written sequences for
// backpressure, flag clearing, misaligned/missing clk_16 edges and mid-frame reset.
module tb_ro_frame_deser;

   localparam int NSLOTS     = 16;
   localparam int BUS_W      = 2;
   localparam int FIFO_DEPTH = 2;
   localparam int FW         = NSLOTS * BUS_W;

   logic             clk_ext   = 1'b0;
   logic             rstb      = 1'b0;
   logic             clk_16    = 1'b0;
   logic [BUS_W-1:0] bus_in    = '0;
   logic             clr_flags = 1'b0;
   logic             out_ready = 1'b1;
   logic [FW-1:0]    out_data;
   logic             out_valid;
   logic             locked;
   logic             sync_err;
   logic             overflow;
   logic [7:0]       frame_cnt;

   int checks = 0;
   int errors = 0;
   logic [FW-1:0] cap[$];

   typedef struct packed {
      logic [FW-1:0] data;
      logic [FW-1:0] exp_data;
      logic [7:0]    exp_cnt;
   } vec_t;

   vec_t tbl [6];

   ro_frame_deser #(
      .NSLOTS    (NSLOTS),
      .BUS_W     (BUS_W),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk_ext  (clk_ext),
      .rstb     (rstb),
      .clk_16   (clk_16),
      .bus_in   (bus_in),
      .clr_flags(clr_flags),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .locked   (locked),
      .sync_err (sync_err),
      .overflow (overflow),
      .frame_cnt(frame_cnt)
   );

   always #5 clk_ext = ~clk_ext;

   // Record every frame the consumer accepts (sampled mid-cycle, after negedge driving)
   always begin
      @(negedge clk_ext);
      #2;
      if (out_valid && out_ready) cap.push_back(out_data);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cap_chk(input string nm, input logic [31:0] exp);
      logic [31:0] v;
      if (cap.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no frame popped, expected %h", nm, exp);
      end else begin
         v = cap.pop_front();
         chk(nm, v, exp);
      end
   endtask

   // One clk_16 period: bus slot i driven at negedge i; the rise for the next frame goes out
   // at i=14 so that its third posedge samples the next frame's slot 0.
   task automatic send_frame(input logic [FW-1:0] data, input bit nxt,
                             input int clr_at = -1, input int rdy_at = -1,
                             input int mis_at = -1, input int rst_at = -1);
      for (int i = 0; i < NSLOTS; i++) begin
         @(negedge clk_ext);
         bus_in = data[i*BUS_W +: BUS_W];
         if (i == 2) clk_16 = 1'b0;
         if (i == 14) clk_16 = nxt;
         if (mis_at >= 0 && i == mis_at) clk_16 = 1'b1;
         if (mis_at >= 0 && i == mis_at + 2) clk_16 = 1'b0;
         if (rdy_at >= 0 && i == rdy_at) out_ready = 1'b1;
         if (clr_at >= 0 && i == clr_at) clr_flags = 1'b1;
         if (clr_at >= 0 && i == clr_at + 1) begin
            clr_flags = 1'b0;
            chk("clr_overflow", overflow, 0);
            chk("clr_sync_err", sync_err, 0);
         end
         if (rst_at >= 0 && i == rst_at) begin
            chk("pre_rst_valid", out_valid, 1);
            rstb = 1'b0;
            #1;
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_locked", locked, 0);
            chk("rst_cnt", frame_cnt, 0);
            chk("rst_sync_err", sync_err, 0);
         end
         if (rst_at >= 0 && i == rst_at + 2) rstb = 1'b1;
      end
   endtask

   initial begin
      tbl[0] = '{32'hE4E4E4E4, 32'hE4E4E4E4, 8'd1};
      tbl[1] = '{32'hE4E4E4E4, 32'hE4E4E4E4, 8'd2};
      tbl[2] = '{32'hE4E4E4E4, 32'hE4E4E4E4, 8'd3};
      tbl[3] = '{32'h12345678, 32'h12345678, 8'd4};
      tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 8'd5};
      tbl[5] = '{32'h8000_0001, 32'h8000_0001, 8'd6};

      repeat (3) @(negedge clk_ext);
      #1;
      chk("reset_valid", out_valid, 0);
      chk("reset_data", out_data, 0);
      chk("reset_locked", locked, 0);
      chk("reset_sync_err", sync_err, 0);
      chk("reset_overflow", overflow, 0);
      chk("reset_cnt", frame_cnt, 0);
      @(negedge clk_ext);
      rstb = 1'b1;

      // Aligned frames
      send_frame(32'h55555555, 1'b1);
      chk("unlocked_pre_edge", locked, 0);
      for (int j = 0; j <= 6; j++) begin
         send_frame(j < 6 ? tbl[j].data : 32'h0, 1'b1);
         if (j == 0) chk("locked_after_rise", locked, 1);
         if (j > 0) begin
            chk("aligned_cnt", frame_cnt, tbl[j-1].exp_cnt);
            chk("aligned_pulses", cap.size(), 1);
            cap_chk("aligned_data", tbl[j-1].exp_data);
         end
      end
      chk("aligned_sync_err", sync_err, 0);

      // Backpressure: A,B queued, C,D dropped
      send_frame(32'hA1A2A3A4, 1'b1);
      cap_chk("trailing_frame", 32'h0);
      chk("trailing_cnt", frame_cnt, 7);
      out_ready = 1'b0;
      send_frame(32'hB1B2B3B4, 1'b1);
      send_frame(32'hC1C2C3C4, 1'b1);
      send_frame(32'hD1D2D3D4, 1'b1);
      send_frame(32'h0F0F0F0F, 1'b1);
      chk("bp_overflow", overflow, 1);
      chk("bp_cnt", frame_cnt, 9);
      chk("bp_valid", out_valid, 1);
      chk("bp_head", out_data, 32'hA1A2A3A4);
      chk("bp_no_pop", cap.size(), 0);

      // clr_flags while full, then a pop coinciding with a push into a full FIFO
      send_frame(32'h3C3C3C3C, 1'b1, 4);
      chk("clr_cnt", frame_cnt, 9);
      send_frame(32'h69696969, 1'b1, -1, 0);
      chk("popush_overflow", overflow, 0);
      chk("popush_cnt", frame_cnt, 10);
      cap_chk("release_a", 32'hA1A2A3A4);
      cap_chk("release_b", 32'hB1B2B3B4);
      cap_chk("popush_frame", 32'h3C3C3C3C);
      chk("popush_count", cap.size(), 0);

      // Misaligned clk_16 rise sampled at slot 7
      send_frame(32'h11223344, 1'b1, -1, -1, 5);
      chk("mis_sync_err", sync_err, 1);
      chk("mis_locked", locked, 1);
      chk("mis_cnt", frame_cnt, 11);
      cap_chk("mis_prev_frame", 32'h69696969);
      send_frame(32'hCAFEF00D, 1'b1);
      chk("mis_partial_dropped", frame_cnt, 11);
      chk("mis_still_locked", locked, 1);

      // Missing clk_16 edges (sync_err cleared first so the new set is visible)
      send_frame(32'hDEADBEEF, 1'b0, 4);
      chk("post_mis_cnt", frame_cnt, 12);
      cap_chk("mis_next_frame", 32'hCAFEF00D);
      send_frame(32'h0BADC0DE, 1'b0);
      chk("miss_locked", locked, 0);
      chk("miss_sync_err", sync_err, 1);
      chk("miss_cnt", frame_cnt, 13);
      cap_chk("miss_last_frame", 32'hDEADBEEF);
      send_frame(32'h13579BDF, 1'b1);
      chk("miss_no_push", frame_cnt, 13);
      chk("miss_no_pop", cap.size(), 0);
      send_frame(32'h2468ACE0, 1'b1);
      chk("relock", locked, 1);
      out_ready = 1'b0;

      // Reset at slot 9 with one frame queued
      send_frame(32'h77777777, 1'b1, -1, -1, -1, 9);
      out_ready = 1'b1;
      send_frame(32'h9ABCDEF0, 1'b1);
      chk("rst_relock", locked, 1);
      chk("rst_relock_cnt", frame_cnt, 0);
      chk("rst_queue_flushed", cap.size(), 0);
      send_frame(32'h0, 1'b1);
      chk("rst_first_cnt", frame_cnt, 1);
      cap_chk("rst_first_frame", 32'h9ABCDEF0);

      repeat (4) @(negedge clk_ext);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ro_frame_deser.md
Name: ro_frame_deser

Overview:
- Receive-side stage directly downstream of the shared readout bus.
- The per-channel readout blocks each drive their 2-bit code onto the tri-state bus in one clk_ext slot of every clk_16 period.
- This block samples the bus each clk_ext cycle, locks slot numbering to clk_16, and assembles one NSLOTS-slot frame word per clk_16 period.
- Completed frames are queued in a small FIFO behind a valid/ready interface, with lock, sync-error and overflow status.

Parameters:
- NSLOTS, 16, slots per frame (= clk_ext cycles per clk_16 period); power of two, 4..64.
- BUS_W, 2, readout bus width.
- FIFO_DEPTH, 2, output frame FIFO entries; power of two, >=2.

Ports:
- clk_ext  in  1  system clock; all state on posedge.
- rstb  in  1  reset.
- clk_16  in  1  divided frame clock, asynchronous to sampling; rising edge marks frame start.
- bus_in  in  BUS_W  shared readout bus.
- clr_flags  in  1  synchronous clear of the sync_err and overflow sticky flags.
- out_data  out  NSLOTS*BUS_W  head-of-FIFO frame.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry when out_valid & out_ready.
- locked  out  1  frame alignment acquired.
- sync_err  out  1  sticky: misplaced or missing clk_16 edge.
- overflow  out  1  sticky: a frame was dropped because the FIFO was full.
- frame_cnt  out  8  count of frames accepted into the FIFO; wraps 255->0.

Behaviour:
- Reset: rstb is asynchronous, active-low.
  - All state clears: FSM=UNLOCKED, slot=0, FIFO empty.
  - Outputs: out_valid=0, out_data=0, locked=0, sync_err=0, overflow=0, frame_cnt=0.
- Synchroniser and edge detect:
  - clk_16 -> s1 -> s2 -> s3 flops.
  - sync_rise = s2 & ~s3 (combinational).
  - If clk_16 rises between clk_ext edges, sync_rise is high after the 2nd posedge.
  - The bus value sampled on the 3rd posedge is slot 0.
- FSM, UNLOCKED:
  - Bus ignored; slot held at 0.
  - On sync_rise: go LOCKED, slot counter armed so the next posedge samples slot 0.
- FSM, LOCKED:
  - Each posedge stores bus_in into frame bits [BUS_W*k +: BUS_W], k = slot; slot then increments modulo NSLOTS.
  - Sample of slot NSLOTS-1 completes the frame. The frame is pushed to the FIFO on the following posedge: out_valid rises 1 cycle after the last sample when the FIFO was empty.
  - sync_rise while slot != 0 (misaligned edge): set sync_err, discard the partial frame, restart at slot 0. Remains LOCKED.
  - Slot wraps to 0 but sync_rise is not high in the cycle preceding the slot-0 sample (missing edge): the completed frame is still pushed; set sync_err; go UNLOCKED.
- FIFO:
  - Push when a frame completes; pop on out_valid & out_ready. out_data is the head entry; it holds stable while out_valid & ~out_ready.
  - Push while full and no pop in the same cycle: frame dropped, overflow set, frame_cnt unchanged.
  - Push while full with a simultaneous pop: pop first, push accepted.
  - frame_cnt increments on each accepted push only.
- clr_flags:
  - Clears sync_err and overflow on the next posedge.
  - If a set event occurs in the same cycle, set wins.
- locked = (FSM==LOCKED).
- Reset mid-frame discards the partial frame and all FIFO contents.

Test Plan:
- Aligned frames:
  - Stimulus: clk_16 = clk_ext/16, changed on clk_ext negedge; bus slot k = k mod 4; out_ready=1.
  - Response: after the first clk_16 rise, locked=1. Each subsequent frame out_data = 32'hE4E4E4E4, one out_valid pulse per 16 cycles, frame_cnt increments 1,2,3; sync_err=0.
- Backpressure/overflow:
  - Stimulus: out_ready=0 for 4 frames, distinct data per frame (A,B,C,D).
  - Response: FIFO holds A,B; C and D dropped; overflow=1; frame_cnt=2. Releasing out_ready yields A then B.
- Misaligned sync:
  - Stimulus: inject an extra clk_16 rise mid-frame so sync_rise occurs at slot 7.
  - Response: sync_err=1, no frame pushed for the partial frame, locked stays 1; the next 16-slot frame is correct.
- Missing sync:
  - Stimulus: hold clk_16 low for 2 periods.
  - Response: one frame still pushed; locked=0; sync_err=1; no further pushes until clk_16 resumes, then relock.
- clr_flags and simultaneous pop/push:
  - Stimulus: with overflow=1, pulse clr_flags.
  - Response: overflow=0 next cycle.
  - Stimulus: FIFO full with a frame completing while out_ready=1.
  - Response: pop and push both occur, overflow stays 0.
- Reset mid-operation:
  - Stimulus: rstb=0 at slot 9 with 1 frame queued.
  - Response: immediately out_valid=0, locked=0, frame_cnt=0; after release, relock on the next clk_16 rise.
